nx_node_msg_encoder: RTL and testbench
======================================

Name: nx_node_msg_encoder

Overview:
- Host-side encoder that turns parallel configuration/stimulus requests into node_message_t beats for injection into the mesh at a boundary node.
- Counterpart of the node-side decoder: emits load, loopback, signal and control messages addressed by row/column.
- Multi-beat commands (RAM word load, loopback mask) are segmented here and reassembled by the target node's decoder.
- Sits between the host interface and one mesh inbound port, on a valid/ready stream.

Parameters:
- INPUTS, 32, node input count; width of loopback mask; index width is $clog2(INPUTS).
- RAM_ADDR_W, 10, node RAM address width.
- RAM_DATA_W, 32, node RAM word width.
- LOAD_SEG_W, 16, data bits per load beat; RAM_DATA_W must be a multiple of it.
- LB_SEG_W, 16, mask bits per loopback beat; INPUTS must be a multiple of it.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request accepted when high with i_req_valid.
- i_req_kind  in  node_command_t  LOAD, LOOPBACK, SIGNAL or CONTROL.
- i_req_target  in  node_id_t  destination row/column.
- i_req_addr  in  RAM_ADDR_W  LOAD: RAM word address.
- i_req_data  in  RAM_DATA_W  LOAD: RAM word.
- i_req_mask  in  INPUTS  LOOPBACK: full mask.
- i_req_index  in  $clog2(INPUTS)  SIGNAL: input index.
- i_req_value  in  1  SIGNAL: input value.
- i_req_is_seq  in  1  SIGNAL: sequential flag.
- i_req_num_instr  in  NODE_PARAM_WIDTH  CONTROL: instruction count.
- i_req_num_output  in  NODE_PARAM_WIDTH  CONTROL: output count.
- o_msg_data  out  MESSAGE_WIDTH  encoded node_message_t.
- o_msg_valid  out  1  message valid.
- i_msg_ready  in  1  downstream ready.
- o_idle  out  1  no request held and no beat pending.
- o_msg_count  out  32  total beats accepted downstream.

Behaviour:
- Reset (async, i_rst=1): state IDLE; o_msg_valid=0, o_msg_data=0, o_req_ready=1, o_idle=1, o_msg_count=0, beat counter=0.
- FSM has two states: IDLE and EMIT.
- IDLE: o_req_ready=1. On i_req_valid:
  - capture all request fields into a holding register;
  - load beat count: LOAD = RAM_DATA_W/LOAD_SEG_W, LOOPBACK = INPUTS/LB_SEG_W, SIGNAL/CONTROL = 1;
  - go to EMIT.
- EMIT: o_req_ready=0; o_msg_valid=1 from the cycle after acceptance (request-to-first-beat latency 1 cycle).
- Beat encoding: header.row/column from the captured target, header.command = kind.
  - LOAD beat k: {addr, seg=k, last=(k==N-1), data[k*LOAD_SEG_W +: LOAD_SEG_W]}, lowest segment first.
  - LOOPBACK beat k: {select=k, mask[k*LB_SEG_W +: LB_SEG_W]}, lowest segment first.
  - SIGNAL: {index, is_seq, value}.
  - CONTROL: {num_instr, num_output}.
  - Unused payload bits are 0.
- Handshake: beat transfers when o_msg_valid && i_msg_ready. While valid && !ready, o_msg_data and o_msg_valid hold stable; valid never drops without a transfer.
- On transfer of a non-last beat: beat counter increments and the next beat is presented the next cycle (no bubble).
- On transfer of the last beat: return to IDLE; o_msg_valid=0 next cycle. The next request is accepted no earlier than that cycle, so there is a 1-cycle gap between requests.
- o_msg_count increments on every transfer and wraps modulo 2^32.
- o_idle = (state==IDLE) && !o_msg_valid.
- A request presented while in EMIT is ignored (ready=0); the requester holds it.
- Reset mid-message: the in-flight beat and the remaining segments are dropped; the partial message is not replayed.
- Illegal i_req_kind: accepted and discarded with no beat emitted; stay in IDLE.

Decomposition:
- NXConstants holds node_command_t, node_header_t, node_id_t, and the payload structs node_load_t, node_loopback_t, node_signal_t, node_control_t, plus MESSAGE_WIDTH and NODE_PARAM_WIDTH. No local redefinitions.
- Sub-module nx_msg_segmenter: holding register, beat counter and output register with the valid/ready hold rule. The top level handles kind decode and payload packing.

Test Plan:
- CONTROL to (2,3), num_instr=5, num_output=7, ready=1 -> one beat 1 cycle after accept; header row=2 col=3 cmd=CONTROL; payload 5/7; o_idle returns to 1.
- LOAD addr=0x12A data=0xDEADBEEF -> two beats: seg0 data 0xBEEF last=0, seg1 data 0xDEAD last=1; both carry addr 0x12A; back-to-back cycles.
- LOOPBACK mask=0x8000_0001, ready low 3 cycles on beat 0 -> beat 0 held stable with mask bits 0x0001 select=0, then beat 1 with 0x8000 select=1; o_msg_count +=2.
- SIGNAL index=31 value=1 is_seq=1 followed by a second request held valid -> second request ready only after the first beat transfers; 1-cycle gap observed.
- Assert i_rst during beat 0 of a LOAD -> o_msg_valid=0 immediately, o_msg_count=0; a subsequent CONTROL emits correctly.
- 10 random mixed requests with random ready -> scoreboard decode matches requests; o_msg_count equals expected beat total.

Source files
------------

// File: rtl/nx_node_msg_encoder_pkg.sv
// Shared node-message definitions: command codes, addressing, payload layouts
// and the host request bundle used by the boundary-node encoder.
package nx_node_msg_encoder_pkg;

   localparam int NX_INPUTS     = 32;
   localparam int NX_RAM_ADDR_W = 10;
   localparam int NX_RAM_DATA_W = 32;
   localparam int NX_LOAD_SEG_W = 16;
   localparam int NX_LB_SEG_W   = 16;

   localparam int NODE_ROW_W       = 4;
   localparam int NODE_COL_W       = 4;
   localparam int NODE_PARAM_WIDTH = 8;

   function automatic int nx_idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int nx_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int INDEX_W        = $clog2(NX_INPUTS);
   localparam int LOAD_BEATS     = NX_RAM_DATA_W / NX_LOAD_SEG_W;
   localparam int LB_BEATS       = NX_INPUTS / NX_LB_SEG_W;
   localparam int LOAD_SEG_IDX_W = nx_idx_w(LOAD_BEATS);
   localparam int LB_SEL_W       = nx_idx_w(LB_BEATS);
   localparam int MAX_BEATS      = nx_max(LOAD_BEATS, LB_BEATS);
   localparam int BEAT_W         = $clog2(MAX_BEATS + 1);

   // Codes 4..7 are reserved; the encoder swallows them without emitting.
   typedef enum logic [2:0] {
      CMD_LOAD     = 3'd0,
      CMD_LOOPBACK = 3'd1,
      CMD_SIGNAL   = 3'd2,
      CMD_CONTROL  = 3'd3
   } node_command_t;

   typedef struct packed {
      logic [NODE_ROW_W-1:0] row;
      logic [NODE_COL_W-1:0] column;
   } node_id_t;

   typedef struct packed {
      logic [NODE_ROW_W-1:0] row;
      logic [NODE_COL_W-1:0] column;
      node_command_t         command;
   } node_header_t;

   typedef struct packed {
      logic [NX_RAM_ADDR_W-1:0]  address;
      logic [LOAD_SEG_IDX_W-1:0] segment;
      logic                      last;
      logic [NX_LOAD_SEG_W-1:0]  data;
   } node_load_t;

   typedef struct packed {
      logic [LB_SEL_W-1:0]    select;
      logic [NX_LB_SEG_W-1:0] mask;
   } node_loopback_t;

   typedef struct packed {
      logic [INDEX_W-1:0] index;
      logic               is_seq;
      logic               value;
   } node_signal_t;

   typedef struct packed {
      logic [NODE_PARAM_WIDTH-1:0] num_instr;
      logic [NODE_PARAM_WIDTH-1:0] num_output;
   } node_control_t;

   localparam int PAYLOAD_WIDTH = nx_max(nx_max($bits(node_load_t), $bits(node_loopback_t)),
                                         nx_max($bits(node_signal_t), $bits(node_control_t)));

   // Payloads sit right-aligned in the payload field, upper bits zero.
   typedef struct packed {
      node_header_t             header;
      logic [PAYLOAD_WIDTH-1:0] payload;
   } node_message_t;

   localparam int MESSAGE_WIDTH = $bits(node_message_t);

   typedef struct packed {
      node_command_t               kind;
      node_id_t                    target;
      logic [NX_RAM_ADDR_W-1:0]    addr;
      logic [NX_RAM_DATA_W-1:0]    data;
      logic [NX_INPUTS-1:0]        mask;
      logic [INDEX_W-1:0]          index;
      logic                        value;
      logic                        is_seq;
      logic [NODE_PARAM_WIDTH-1:0] num_instr;
      logic [NODE_PARAM_WIDTH-1:0] num_output;
   } node_request_t;

endpackage

// File: rtl/nx_msg_segmenter.sv
// Request holding register, beat sequencer and registered valid/ready output
// stage; the parent supplies the beat count and the encoding of each beat.
module nx_msg_segmenter
   import nx_node_msg_encoder_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_req_valid,
   output logic                o_req_ready,
   input  node_request_t       i_req,
   input  logic [BEAT_W-1:0]   i_req_beats,
   output node_request_t       o_enc_req,
   output logic [BEAT_W-1:0]   o_enc_beat,
   input  node_message_t       i_enc_msg,
   output node_message_t       o_msg,
   output logic                o_msg_valid,
   input  logic                i_msg_ready,
   output logic                o_idle,
   output logic [31:0]         o_msg_count
);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   node_request_t       hold_q;
   node_message_t       msg_q;
   logic [BEAT_W-1:0]   total_q;
   logic [BEAT_W-1:0]   beat_q;
   logic [31:0]         count_q;
   logic                start;
   logic                xfer;
   logic                last_beat;

   // A zero beat count marks an illegal kind: accepted but never emitted.
   assign start     = (state_q == IDLE) && i_req_valid && (i_req_beats != '0);
   assign xfer      = (state_q == EMIT) && i_msg_ready;
   assign last_beat = (beat_q == total_q - 1'b1);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      state_d    = state_q;
      o_enc_req  = hold_q;
      o_enc_beat = beat_q + 1'b1;
      case (state_q)
         IDLE: begin
            o_enc_req  = i_req;
            o_enc_beat = '0;
            if (start) state_d = EMIT;
         end
         EMIT: begin
            if (xfer && last_beat) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // The first beat is encoded from the live request so it appears one cycle after acceptance.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         hold_q  <= '0;
         msg_q   <= '0;
         total_q <= '0;
         beat_q  <= '0;
         count_q <= '0;
      end else begin
         if (xfer) count_q <= count_q + 32'd1;
         if (start) begin
            hold_q  <= i_req;
            total_q <= i_req_beats;
            beat_q  <= '0;
            msg_q   <= i_enc_msg;
         end else if (xfer) begin
            if (last_beat) begin
               beat_q <= '0;
               msg_q  <= '0;
            end else begin
               beat_q <= beat_q + 1'b1;
               msg_q  <= i_enc_msg;
            end
         end
      end
   end

   assign o_req_ready = (state_q == IDLE);
   assign o_msg_valid = (state_q == EMIT);
   assign o_idle      = (state_q == IDLE) && !o_msg_valid;
   assign o_msg       = msg_q;
   assign o_msg_count = count_q;

endmodule

// File: rtl/nx_node_msg_encoder.sv
// Host-side encoder: packs LOAD/LOOPBACK/SIGNAL/CONTROL requests into
// node_message_t beats for a mesh inbound port, segmenting multi-beat commands.
module nx_node_msg_encoder
   import nx_node_msg_encoder_pkg::*;
#(
   parameter int INPUTS     = NX_INPUTS,
   parameter int RAM_ADDR_W = NX_RAM_ADDR_W,
   parameter int RAM_DATA_W = NX_RAM_DATA_W,
   parameter int LOAD_SEG_W = NX_LOAD_SEG_W,
   parameter int LB_SEG_W   = NX_LB_SEG_W
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_req_valid,
   output logic                        o_req_ready,
   input  node_command_t               i_req_kind,
   input  node_id_t                    i_req_target,
   input  logic [RAM_ADDR_W-1:0]       i_req_addr,
   input  logic [RAM_DATA_W-1:0]       i_req_data,
   input  logic [INPUTS-1:0]           i_req_mask,
   input  logic [$clog2(INPUTS)-1:0]   i_req_index,
   input  logic                        i_req_value,
   input  logic                        i_req_is_seq,
   input  logic [NODE_PARAM_WIDTH-1:0] i_req_num_instr,
   input  logic [NODE_PARAM_WIDTH-1:0] i_req_num_output,
   output logic [MESSAGE_WIDTH-1:0]    o_msg_data,
   output logic                        o_msg_valid,
   input  logic                        i_msg_ready,
   output logic                        o_idle,
   output logic [31:0]                 o_msg_count
);

   node_request_t     req;
   node_request_t     enc_req;
   logic [BEAT_W-1:0] enc_beat;
   node_message_t     enc_msg;
   node_message_t     msg;
   logic [BEAT_W-1:0] req_beats;

   function automatic logic [BEAT_W-1:0] beats_for(input node_command_t kind);
      logic [BEAT_W-1:0] n;
      case (kind)
         CMD_LOAD:     n = BEAT_W'(RAM_DATA_W / LOAD_SEG_W);
         CMD_LOOPBACK: n = BEAT_W'(INPUTS / LB_SEG_W);
         CMD_SIGNAL:   n = BEAT_W'(1);
         CMD_CONTROL:  n = BEAT_W'(1);
         default:      n = '0;
      endcase
      return n;
   endfunction

   // Segments go out lowest-first: beat k carries bits [k*SEG_W +: SEG_W].
   function automatic node_message_t encode(input node_request_t r, input logic [BEAT_W-1:0] k);
      node_message_t  m;
      node_load_t     ld;
      node_loopback_t lb;
      node_signal_t   sg;
      node_control_t  ct;
      m  = '0;
      ld = '0;
      lb = '0;
      sg = '0;
      ct = '0;
      m.header.row     = r.target.row;
      m.header.column  = r.target.column;
      m.header.command = r.kind;
      case (r.kind)
         CMD_LOAD: begin
            ld.address = r.addr;
            ld.segment = k[LOAD_SEG_IDX_W-1:0];
            ld.last    = (k == BEAT_W'(RAM_DATA_W / LOAD_SEG_W - 1));
            ld.data    = LOAD_SEG_W'(r.data >> (int'(k) * LOAD_SEG_W));
            m.payload  = PAYLOAD_WIDTH'(ld);
         end
         CMD_LOOPBACK: begin
            lb.select = k[LB_SEL_W-1:0];
            lb.mask   = LB_SEG_W'(r.mask >> (int'(k) * LB_SEG_W));
            m.payload = PAYLOAD_WIDTH'(lb);
         end
         CMD_SIGNAL: begin
            sg.index  = r.index;
            sg.is_seq = r.is_seq;
            sg.value  = r.value;
            m.payload = PAYLOAD_WIDTH'(sg);
         end
         CMD_CONTROL: begin
            ct.num_instr  = r.num_instr;
            ct.num_output = r.num_output;
            m.payload     = PAYLOAD_WIDTH'(ct);
         end
         default: m = '0;
      endcase
      return m;
   endfunction

   always_comb begin
      req            = '0;
      req.kind       = i_req_kind;
      req.target     = i_req_target;
      req.addr       = i_req_addr;
      req.data       = i_req_data;
      req.mask       = i_req_mask;
      req.index      = i_req_index;
      req.value      = i_req_value;
      req.is_seq     = i_req_is_seq;
      req.num_instr  = i_req_num_instr;
      req.num_output = i_req_num_output;
   end

   assign req_beats = beats_for(i_req_kind);
   assign enc_msg   = encode(enc_req, enc_beat);

   nx_msg_segmenter u_segmenter (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_req_valid (i_req_valid),
      .o_req_ready (o_req_ready),
      .i_req       (req),
      .i_req_beats (req_beats),
      .o_enc_req   (enc_req),
      .o_enc_beat  (enc_beat),
      .i_enc_msg   (enc_msg),
      .o_msg       (msg),
      .o_msg_valid (o_msg_valid),
      .i_msg_ready (i_msg_ready),
      .o_idle      (o_idle),
      .o_msg_count (o_msg_count)
   );

   assign o_msg_data = msg;

endmodule

// File: tb/tb_nx_node_msg_encoder.sv
// Scoreboard bench for nx_node_msg_encoder: expected beats are queued when a
// request is accepted and compared as the DUT hands beats downstream.
module tb_nx_node_msg_encoder;
   import nx_node_msg_encoder_pkg::*;

   logic                        i_clk = 1'b0;
   logic                        i_rst;
   logic                        i_req_valid;
   logic                        o_req_ready;
   node_command_t               i_req_kind;
   node_id_t                    i_req_target;
   logic [9:0]                  i_req_addr;
   logic [31:0]                 i_req_data;
   logic [31:0]                 i_req_mask;
   logic [4:0]                  i_req_index;
   logic                        i_req_value;
   logic                        i_req_is_seq;
   logic [7:0]                  i_req_num_instr;
   logic [7:0]                  i_req_num_output;
   logic [MESSAGE_WIDTH-1:0]    o_msg_data;
   logic                        o_msg_valid;
   logic                        i_msg_ready;
   logic                        o_idle;
   logic [31:0]                 o_msg_count;

   typedef struct {
      logic [2:0]  kind;
      logic [3:0]  row;
      logic [3:0]  col;
      logic [9:0]  addr;
      logic [31:0] data;
      logic [31:0] mask;
      logic [4:0]  idx;
      logic        val;
      logic        seq;
      logic [7:0]  ni;
      logic [7:0]  no;
   } tb_req_t;

   int checks = 0;
   int errors = 0;
   logic [MESSAGE_WIDTH-1:0] exp_q[$];
   logic                     held = 1'b0;
   logic [MESSAGE_WIDTH-1:0] held_data;

   nx_node_msg_encoder dut (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_req_valid      (i_req_valid),
      .o_req_ready      (o_req_ready),
      .i_req_kind       (i_req_kind),
      .i_req_target     (i_req_target),
      .i_req_addr       (i_req_addr),
      .i_req_data       (i_req_data),
      .i_req_mask       (i_req_mask),
      .i_req_index      (i_req_index),
      .i_req_value      (i_req_value),
      .i_req_is_seq     (i_req_is_seq),
      .i_req_num_instr  (i_req_num_instr),
      .i_req_num_output (i_req_num_output),
      .o_msg_data       (o_msg_data),
      .o_msg_valid      (o_msg_valid),
      .i_msg_ready      (i_msg_ready),
      .o_idle           (o_idle),
      .o_msg_count      (o_msg_count)
   );

   always #5 i_clk = ~i_clk;

   function automatic int model_beats(input logic [2:0] kind);
      case (kind)
         3'd0, 3'd1: return 2;
         3'd2, 3'd3: return 1;
         default:    return 0;
      endcase
   endfunction

   // Message = {row, col, cmd, 28-bit payload}; payload layouts written out by hand.
   function automatic logic [MESSAGE_WIDTH-1:0] model_beat(input tb_req_t r, input int k);
      logic [10:0] hdr;
      logic [27:0] pl;
      hdr = {r.row, r.col, r.kind};
      case (r.kind)
         3'd0:    pl = {r.addr, k[0], (k == 1), (k == 0) ? r.data[15:0] : r.data[31:16]};
         3'd1:    pl = {11'd0, k[0], (k == 0) ? r.mask[15:0] : r.mask[31:16]};
         3'd2:    pl = {21'd0, r.idx, r.seq, r.val};
         3'd3:    pl = {12'd0, r.ni, r.no};
         default: pl = '0;
      endcase
      return {hdr, pl};
   endfunction

   // Downstream monitor: stability while stalled, scoreboard compare on transfer.
   always @(negedge i_clk) begin
      logic [MESSAGE_WIDTH-1:0] exp;
      if (i_rst) begin
         held = 1'b0;
      end else begin
         if (held) begin
            checks++;
            if (!o_msg_valid) begin
               errors++;
               $display("FAIL valid_dropped: valid=%0b required 1 (no transfer happened)", o_msg_valid);
            end else if (o_msg_data !== held_data) begin
               errors++;
               $display("FAIL hold_stable: data=%h required %h", o_msg_data, held_data);
            end
         end
         if (o_msg_valid && i_msg_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat: data=%h required none", o_msg_data);
            end else begin
               exp = exp_q.pop_front();
               if (o_msg_data !== exp) begin
                  errors++;
                  $display("FAIL beat_data: data=%h required %h", o_msg_data, exp);
               end
            end
            held = 1'b0;
         end else if (o_msg_valid) begin
            held      = 1'b1;
            held_data = o_msg_data;
         end else begin
            held = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive_fields(input tb_req_t r);
      i_req_kind             = node_command_t'(r.kind);
      i_req_target.row       = r.row;
      i_req_target.column    = r.col;
      i_req_addr             = r.addr;
      i_req_data             = r.data;
      i_req_mask             = r.mask;
      i_req_index            = r.idx;
      i_req_value            = r.val;
      i_req_is_seq           = r.seq;
      i_req_num_instr        = r.ni;
      i_req_num_output       = r.no;
   endtask

   task automatic push_model(input tb_req_t r);
      for (int k = 0; k < model_beats(r.kind); k++) exp_q.push_back(model_beat(r, k));
   endtask

   // Returns #1 after the accepting edge with i_req_valid dropped.
   task automatic send_req(input tb_req_t r);
      bit ok;
      ok = 1'b0;
      @(posedge i_clk);
      #1;
      drive_fields(r);
      i_req_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge i_clk);
         if (o_req_ready) begin
            ok = 1'b1;
            push_model(r);
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: req_ready=%0b required 1", o_req_ready);
         i_req_valid = 1'b0;
         return;
      end
      @(posedge i_clk);
      #1;
      i_req_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge i_clk);
         if (exp_q.size() == 0 && o_idle) begin
            done = 1'b1;
            break;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s_drain: pending=%0d idle=%0b required 0/1", name, exp_q.size(), o_idle);
      end
   endtask

   function automatic tb_req_t mk_req(input logic [2:0] kind, input logic [3:0] row, input logic [3:0] col);
      tb_req_t r;
      r = '{kind: kind, row: row, col: col, addr: '0, data: '0, mask: '0,
            idx: '0, val: 1'b0, seq: 1'b0, ni: '0, no: '0};
      return r;
   endfunction

   task automatic test_reset();
      i_rst       = 1'b1;
      i_req_valid = 1'b0;
      i_msg_ready = 1'b0;
      drive_fields(mk_req(3'd0, 4'd0, 4'd0));
      repeat (2) @(negedge i_clk);
      checks++;
      if (o_msg_valid !== 1'b0 || o_msg_data !== '0 || o_req_ready !== 1'b1 ||
          o_idle !== 1'b1 || o_msg_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_state: valid=%0b data=%h ready=%0b idle=%0b count=%0d required 0/0/1/1/0",
                  o_msg_valid, o_msg_data, o_req_ready, o_idle, o_msg_count);
      end
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
   endtask

   task automatic test_control();
      tb_req_t r;
      logic [31:0] c0;
      r = mk_req(3'd3, 4'd2, 4'd3);
      r.ni = 8'd5;
      r.no = 8'd7;
      i_msg_ready = 1'b1;
      c0 = o_msg_count;
      send_req(r);
      checks++;
      if (o_msg_valid !== 1'b1 || o_req_ready !== 1'b0 || o_idle !== 1'b0) begin
         errors++;
         $display("FAIL control_latency: valid=%0b ready=%0b idle=%0b required 1/0/0",
                  o_msg_valid, o_req_ready, o_idle);
      end
      wait_drain("control");
      checks++;
      if (o_idle !== 1'b1 || o_msg_count !== c0 + 32'd1) begin
         errors++;
         $display("FAIL control_done: idle=%0b count=%0d required 1/%0d", o_idle, o_msg_count, c0 + 1);
      end
   endtask

   task automatic test_load();
      tb_req_t r;
      logic [31:0] c0;
      r = mk_req(3'd0, 4'd1, 4'd4);
      r.addr = 10'h12A;
      r.data = 32'hDEADBEEF;
      i_msg_ready = 1'b1;
      c0 = o_msg_count;
      send_req(r);
      checks++;
      if (o_msg_valid !== 1'b1) begin
         errors++;
         $display("FAIL load_beat0: valid=%0b required 1", o_msg_valid);
      end
      @(posedge i_clk);
      #1;
      checks++;
      if (o_msg_valid !== 1'b1 || o_msg_count !== c0 + 32'd1) begin
         errors++;
         $display("FAIL load_no_bubble: valid=%0b count=%0d required 1/%0d", o_msg_valid, o_msg_count, c0 + 1);
      end
      @(posedge i_clk);
      #1;
      checks++;
      if (o_msg_valid !== 1'b0 || o_msg_count !== c0 + 32'd2 || o_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL load_end: valid=%0b count=%0d ready=%0b required 0/%0d/1",
                  o_msg_valid, o_msg_count, o_req_ready, c0 + 2);
      end
      wait_drain("load");
   endtask

   task automatic test_loopback_stall();
      tb_req_t r;
      logic [31:0] c0;
      r = mk_req(3'd1, 4'd7, 4'd0);
      r.mask = 32'h8000_0001;
      i_msg_ready = 1'b0;
      c0 = o_msg_count;
      send_req(r);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (o_msg_valid !== 1'b1 || o_msg_count !== c0) begin
            errors++;
            $display("FAIL loopback_stall: valid=%0b count=%0d required 1/%0d", o_msg_valid, o_msg_count, c0);
         end
         @(posedge i_clk);
         #1;
      end
      i_msg_ready = 1'b1;
      wait_drain("loopback");
      checks++;
      if (o_msg_count !== c0 + 32'd2) begin
         errors++;
         $display("FAIL loopback_count: count=%0d required %0d", o_msg_count, c0 + 2);
      end
   endtask

   task automatic test_back_to_back();
      tb_req_t r1, r2;
      r1 = mk_req(3'd2, 4'd5, 4'd6);
      r1.idx = 5'd31;
      r1.val = 1'b1;
      r1.seq = 1'b1;
      r2 = mk_req(3'd3, 4'd15, 4'd15);
      r2.ni = 8'hA5;
      r2.no = 8'h3C;
      i_msg_ready = 1'b1;
      send_req(r1);
      drive_fields(r2);
      i_req_valid = 1'b1;
      checks++;
      if (o_req_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_busy: ready=%0b required 0", o_req_ready);
      end
      @(posedge i_clk);
      #1;
      checks++;
      if (o_msg_valid !== 1'b0 || o_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_gap: valid=%0b ready=%0b required 0/1", o_msg_valid, o_req_ready);
      end
      push_model(r2);
      @(posedge i_clk);
      #1;
      i_req_valid = 1'b0;
      checks++;
      if (o_msg_valid !== 1'b1 || o_req_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second: valid=%0b ready=%0b required 1/0", o_msg_valid, o_req_ready);
      end
      wait_drain("b2b");
   endtask

   task automatic test_reset_mid();
      tb_req_t r;
      r = mk_req(3'd0, 4'd3, 4'd3);
      r.addr = 10'h3FF;
      r.data = 32'h1234_5678;
      i_msg_ready = 1'b0;
      send_req(r);
      #2;
      i_rst = 1'b1;
      #1;
      checks++;
      if (o_msg_valid !== 1'b0 || o_msg_count !== 32'd0 || o_msg_data !== '0) begin
         errors++;
         $display("FAIL reset_mid: valid=%0b count=%0d data=%h required 0/0/0",
                  o_msg_valid, o_msg_count, o_msg_data);
      end
      exp_q.delete();
      @(negedge i_clk);
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      r = mk_req(3'd3, 4'd9, 4'd1);
      r.ni = 8'd1;
      r.no = 8'd2;
      i_msg_ready = 1'b1;
      send_req(r);
      wait_drain("reset_mid");
      checks++;
      if (o_msg_count !== 32'd1) begin
         errors++;
         $display("FAIL reset_mid_count: count=%0d required 1", o_msg_count);
      end
   endtask

   task automatic test_illegal();
      tb_req_t r;
      logic [31:0] c0;
      r = mk_req(3'd5, 4'd2, 4'd2);
      i_msg_ready = 1'b1;
      c0 = o_msg_count;
      send_req(r);
      for (int i = 0; i < 3; i++) begin
         @(negedge i_clk);
         checks++;
         if (o_msg_valid !== 1'b0 || o_idle !== 1'b1) begin
            errors++;
            $display("FAIL illegal_kind: valid=%0b idle=%0b required 0/1", o_msg_valid, o_idle);
         end
      end
      checks++;
      if (o_msg_count !== c0) begin
         errors++;
         $display("FAIL illegal_count: count=%0d required %0d", o_msg_count, c0);
      end
   endtask

   task automatic test_random();
      logic [31:0] c0;
      int          total;
      bit          stop;
      c0    = o_msg_count;
      total = 0;
      stop  = 1'b0;
      fork
         begin
            for (int n = 0; n < 10; n++) begin
               tb_req_t r;
               r = mk_req(3'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
               r.addr = 10'($urandom);
               r.data = $urandom;
               r.mask = $urandom;
               r.idx  = 5'($urandom);
               r.val  = 1'($urandom);
               r.seq  = 1'($urandom);
               r.ni   = 8'($urandom);
               r.no   = 8'($urandom);
               total += model_beats(r.kind);
               send_req(r);
            end
            wait_drain("random");
            stop = 1'b1;
         end
         begin
            while (!stop) begin
               @(posedge i_clk);
               #1;
               i_msg_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      i_msg_ready = 1'b1;
      checks++;
      if (o_msg_count !== c0 + 32'(total)) begin
         errors++;
         $display("FAIL random_count: count=%0d required %0d", o_msg_count, c0 + 32'(total));
      end
   endtask

   initial begin
      test_reset();
      test_control();
      test_load();
      test_loopback_stall();
      test_back_to_back();
      test_reset_mid();
      test_illegal();
      test_random();
      repeat (2) @(posedge i_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
